// File: rtl/axis_seg_pick.sv
// Lowest-set-index priority encoder over the segment mask of the holding
// register. Segment 0 sits in the LSBs and is always emitted first.
module axis_seg_pick #(
  parameter int SEG_COUNT = 8,
  parameter int IDX_W     = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1
) (
  input  logic [SEG_COUNT-1:0] seg_mask_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o,
  output logic [SEG_COUNT-1:0] mask_next_o,
  output logic                 last_seg_o
);

  // Scan from the top down so the lowest set bit is the final winner
  always_comb begin
    idx_o = '0;
    for (int i = SEG_COUNT - 1; i >= 0; i--) begin
      if (seg_mask_i[i]) begin
        idx_o = IDX_W'(i);
      end else begin
        idx_o = idx_o;
      end
    end
  end

  assign any_o = |seg_mask_i;

  // x & (x - 1) clears exactly the lowest set bit
  assign mask_next_o = seg_mask_i & (seg_mask_i - SEG_COUNT'(1));

  // Exactly one segment left: the segment being picked is the final one
  assign last_seg_o = any_o && (mask_next_o == '0);

endmodule

// File: rtl/axis_width_downsizer.sv
// AXI4-Stream narrowing converter: one wide beat is parked in a holding
// register and emitted as narrow segments, lowest segment first. Segments
// with no keep bits are skipped, an all-empty last beat still produces one
// zero-keep tlast beat so the frame boundary survives, and an all-empty
// non-last beat is silently dropped.
module axis_width_downsizer #(
  parameter int S_DATA_WIDTH  = 64,
  parameter int S_KEEP_WIDTH  = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH  = 8,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = M_DATA_WIDTH / 8,
  parameter bit ID_ENABLE     = 1'b0,
  parameter int ID_WIDTH      = 8,
  parameter bit DEST_ENABLE   = 1'b0,
  parameter int DEST_WIDTH    = 8,
  parameter bit USER_ENABLE   = 1'b1,
  parameter int USER_WIDTH    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    m_status_frame_done
);

  localparam int SEG_COUNT  = S_KEEP_WIDTH / M_KEEP_WIDTH;
  localparam int SEG_DATA_W = S_DATA_WIDTH / SEG_COUNT;
  localparam int IDX_W      = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

  // Elaboration-time sanity checks on the width ratio
  if ((S_DATA_WIDTH % M_DATA_WIDTH) != 0 || (S_KEEP_WIDTH % M_KEEP_WIDTH) != 0) begin : g_bad_ratio
    $error("axis_width_downsizer: M width must evenly divide S width");
  end
  if ((S_DATA_WIDTH / S_KEEP_WIDTH) != (M_DATA_WIDTH / M_KEEP_WIDTH)) begin : g_bad_word
    $error("axis_width_downsizer: S and M word sizes differ");
  end
  if (SEG_COUNT < 2) begin : g_bad_count
    $error("axis_width_downsizer: segment count must be at least 2");
  end

  // One mask bit per segment: set when any lane of that segment is kept
  function automatic logic [SEG_COUNT-1:0] keep_to_mask(input logic [S_KEEP_WIDTH-1:0] keep);
    logic [SEG_COUNT-1:0] mask;
    mask = '0;
    for (int i = 0; i < SEG_COUNT; i++) begin
      mask[i] = |keep[i*M_KEEP_WIDTH +: M_KEEP_WIDTH];
    end
    return mask;
  endfunction

  // Holding register (one wide beat)
  logic                    hold_valid_q, hold_valid_d;
  logic [S_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [S_KEEP_WIDTH-1:0] hold_keep_q, hold_keep_d;
  logic                    hold_last_q, hold_last_d;
  logic [ID_WIDTH-1:0]     hold_id_q, hold_id_d;
  logic [DEST_WIDTH-1:0]   hold_dest_q, hold_dest_d;
  logic [USER_WIDTH-1:0]   hold_user_q, hold_user_d;
  logic [SEG_COUNT-1:0]    seg_mask_q, seg_mask_d;

  // Output register (one narrow beat)
  logic                    m_valid_q, m_valid_d;
  logic [M_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [M_KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                    m_last_q, m_last_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;
  logic [DEST_WIDTH-1:0]   m_dest_q, m_dest_d;
  logic [USER_WIDTH-1:0]   m_user_q, m_user_d;
  logic                    frame_done_q, frame_done_d;

  // Segment picker results
  logic [IDX_W-1:0]        pick_idx_s;
  logic                    pick_any_s;
  logic [SEG_COUNT-1:0]    pick_mask_next_s;
  logic                    pick_last_s;

  // Datapath / handshake helpers
  logic                    out_load_s;
  logic                    hold_drop_s;
  logic                    emit_s;
  logic                    drain_s;
  logic                    s_ready_s;
  logic                    s_fire_s;
  logic [SEG_DATA_W-1:0]   seg_data_s;
  logic [M_KEEP_WIDTH-1:0] seg_keep_s;

  axis_seg_pick #(
    .SEG_COUNT (SEG_COUNT),
    .IDX_W     (IDX_W)
  ) u_seg_pick (
    .seg_mask_i  (seg_mask_q),
    .idx_o       (pick_idx_s),
    .any_o       (pick_any_s),
    .mask_next_o (pick_mask_next_s),
    .last_seg_o  (pick_last_s)
  );

  assign out_load_s  = !m_valid_q || m_axis_tready;
  // Empty non-last beat: nothing to emit, just let it go
  assign hold_drop_s = hold_valid_q && !pick_any_s && !hold_last_q;
  // Emit a data segment, or the single zero-keep beat of an empty last beat
  assign emit_s      = out_load_s && hold_valid_q && (pick_any_s || hold_last_q);
  // The hold register empties with this emit
  assign drain_s     = emit_s && (pick_last_s || !pick_any_s);
  // Accept a new beat when the hold is free or is handing off its final segment now
  assign s_ready_s   = !rst && (!hold_valid_q || hold_drop_s || (pick_last_s && out_load_s));
  assign s_fire_s    = s_axis_tvalid && s_ready_s;

  // Mux out the data and keep lanes of the picked segment
  always_comb begin
    seg_data_s = '0;
    seg_keep_s = '0;
    for (int i = 0; i < SEG_COUNT; i++) begin
      if (pick_idx_s == IDX_W'(i)) begin
        seg_data_s = hold_data_q[i*SEG_DATA_W +: SEG_DATA_W];
        seg_keep_s = hold_keep_q[i*M_KEEP_WIDTH +: M_KEEP_WIDTH];
      end else begin
        seg_data_s = seg_data_s;
        seg_keep_s = seg_keep_s;
      end
    end
  end

  // Holding register next state: load a new beat, retire a segment, or empty out
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_last_d  = hold_last_q;
    hold_id_d    = hold_id_q;
    hold_dest_d  = hold_dest_q;
    hold_user_d  = hold_user_q;
    seg_mask_d   = seg_mask_q;
    if (s_fire_s) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_axis_tdata;
      hold_keep_d  = s_axis_tkeep;
      hold_last_d  = s_axis_tlast;
      hold_id_d    = ID_ENABLE   ? s_axis_tid   : '0;
      hold_dest_d  = DEST_ENABLE ? s_axis_tdest : '0;
      hold_user_d  = USER_ENABLE ? s_axis_tuser : '0;
      seg_mask_d   = keep_to_mask(s_axis_tkeep);
    end else if (drain_s || hold_drop_s) begin
      hold_valid_d = 1'b0;
      seg_mask_d   = '0;
    end else if (emit_s) begin
      seg_mask_d   = pick_mask_next_s;
    end else begin
      seg_mask_d   = seg_mask_q;
    end
  end

  // Output register next state: load a segment when the sink can take it, else hold
  always_comb begin
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    m_id_d       = m_id_q;
    m_dest_d     = m_dest_q;
    m_user_d     = m_user_q;
    frame_done_d = m_valid_q && m_axis_tready && m_last_q;
    if (emit_s) begin
      m_valid_d = 1'b1;
      m_id_d    = hold_id_q;
      m_dest_d  = hold_dest_q;
      if (pick_any_s) begin
        m_data_d = seg_data_s;
        m_keep_d = M_KEEP_ENABLE ? seg_keep_s : '1;
        m_last_d = hold_last_q && pick_last_s;
        m_user_d = (hold_last_q && pick_last_s) ? hold_user_q : '0;
      end else begin
        m_data_d = '0;
        m_keep_d = '0;
        m_last_d = 1'b1;
        m_user_d = hold_user_q;
      end
    end else if (out_load_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State registers with synchronous reset flushing hold and output stages
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_id_q    <= '0;
      hold_dest_q  <= '0;
      hold_user_q  <= '0;
      seg_mask_q   <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      m_id_q       <= '0;
      m_dest_q     <= '0;
      m_user_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_last_q  <= hold_last_d;
      hold_id_q    <= hold_id_d;
      hold_dest_q  <= hold_dest_d;
      hold_user_q  <= hold_user_d;
      seg_mask_q   <= seg_mask_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
      m_id_q       <= m_id_d;
      m_dest_q     <= m_dest_d;
      m_user_q     <= m_user_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_axis_tready       = s_ready_s;
  assign m_axis_tdata        = m_data_q;
  assign m_axis_tkeep        = m_keep_q;
  assign m_axis_tvalid       = m_valid_q;
  assign m_axis_tlast        = m_last_q;
  assign m_axis_tid          = m_id_q;
  assign m_axis_tdest        = m_dest_q;
  assign m_axis_tuser        = m_user_q;
  assign m_status_frame_done = frame_done_q;

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed self-checking bench for the 64b -> 8b AXI4-Stream downsizer.
module tb_axis_width_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  s_tid;
  logic [7:0]  s_tdest;
  logic [0:0]  s_tuser;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  m_tid;
  logic [7:0]  m_tdest;
  logic [0:0]  m_tuser;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic       u;
    int         e;
  } beat_t;

  beat_t obs[$];

  axis_width_downsizer dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_axis_tdata        (s_tdata),
    .s_axis_tkeep        (s_tkeep),
    .s_axis_tvalid       (s_tvalid),
    .s_axis_tready       (s_tready),
    .s_axis_tlast        (s_tlast),
    .s_axis_tid          (s_tid),
    .s_axis_tdest        (s_tdest),
    .s_axis_tuser        (s_tuser),
    .m_axis_tdata        (m_tdata),
    .m_axis_tkeep        (m_tkeep),
    .m_axis_tvalid       (m_tvalid),
    .m_axis_tready       (m_tready),
    .m_axis_tlast        (m_tlast),
    .m_axis_tid          (m_tid),
    .m_axis_tdest        (m_tdest),
    .m_axis_tuser        (m_tuser),
    .m_status_frame_done (frame_done)
  );

  // Clock
  always #5 clk = ~clk;

  // Edge counter
  always @(posedge clk) cyc <= cyc + 1;

  // Record each output transfer (taken at the next rising edge) and frame_done pulses
  always @(negedge clk) begin
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      obs.push_back('{m_tdata, m_tkeep[0], m_tlast, m_tuser[0], cyc + 1});
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one wide beat and wait (bounded) for its handshake; hs = handshake edge number
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic u, output int hs);
    int n;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    n = 0;
    while (s_tready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL send_timeout s_tready stuck at %b, required 1", s_tready);
    end
    @(posedge clk);
    #1;
    hs = cyc;
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b exp 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b exp 0", m_tvalid); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_m_tdata got %h exp 00", m_tdata); end
    checks++; if (m_tkeep !== 1'b0) begin errors++; $display("FAIL reset_m_tkeep got %b exp 0", m_tkeep); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast got %b exp 0", m_tlast); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    rst = 1'b0;
    tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready got %b exp 1", s_tready); end
  endtask

  task automatic test_single();
    int b, f, hs;
    b = obs.size();
    f = fd_cnt;
    send_beat(64'h0807060504030201, 8'hFF, 1'b1, 1'b0, hs);
    repeat (14) tick();
    checks++; if (obs.size() - b !== 8) begin errors++; $display("FAIL single_count got %0d exp 8", obs.size() - b); end
    for (int i = 0; i < 8 && b + i < obs.size(); i++) begin
      checks++; if (obs[b+i].d !== 8'(i + 1)) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", i, obs[b+i].d, 8'(i + 1)); end
      checks++; if (obs[b+i].l !== (i == 7)) begin errors++; $display("FAIL single_last[%0d] got %b exp %b", i, obs[b+i].l, (i == 7)); end
      checks++; if (obs[b+i].k !== 1'b1) begin errors++; $display("FAIL single_keep[%0d] got %b exp 1", i, obs[b+i].k); end
      checks++; if (obs[b+i].e !== hs + 2 + i) begin errors++; $display("FAIL single_timing[%0d] got edge %0d exp %0d", i, obs[b+i].e, hs + 2 + i); end
    end
    checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL single_frame_done got %0d pulses exp 1", fd_cnt - f); end
  endtask

  task automatic test_partial();
    int b, hs;
    b = obs.size();
    send_beat(64'h0807060504030201, 8'h0F, 1'b1, 1'b0, hs);
    repeat (10) tick();
    checks++; if (obs.size() - b !== 4) begin errors++; $display("FAIL partial_count got %0d exp 4", obs.size() - b); end
    for (int i = 0; i < 4 && b + i < obs.size(); i++) begin
      checks++; if (obs[b+i].d !== 8'(i + 1)) begin errors++; $display("FAIL partial_data[%0d] got %h exp %h", i, obs[b+i].d, 8'(i + 1)); end
      checks++; if (obs[b+i].l !== (i == 3)) begin errors++; $display("FAIL partial_last[%0d] got %b exp %b", i, obs[b+i].l, (i == 3)); end
    end
  endtask

  task automatic test_sparse();
    int b, hs;
    logic [7:0] exp_d [3];
    logic       exp_l [3];
    exp_d = '{8'h01, 8'h08, 8'h01};
    exp_l = '{1'b0, 1'b0, 1'b1};
    b = obs.size();
    send_beat(64'h0807060504030201, 8'h81, 1'b0, 1'b0, hs);
    send_beat(64'h0807060504030201, 8'h01, 1'b1, 1'b0, hs);
    repeat (8) tick();
    checks++; if (obs.size() - b !== 3) begin errors++; $display("FAIL sparse_count got %0d exp 3", obs.size() - b); end
    for (int i = 0; i < 3 && b + i < obs.size(); i++) begin
      checks++; if (obs[b+i].d !== exp_d[i]) begin errors++; $display("FAIL sparse_data[%0d] got %h exp %h", i, obs[b+i].d, exp_d[i]); end
      checks++; if (obs[b+i].l !== exp_l[i]) begin errors++; $display("FAIL sparse_last[%0d] got %b exp %b", i, obs[b+i].l, exp_l[i]); end
    end
  endtask

  task automatic test_empty();
    int b, f, hs;
    b = obs.size();
    send_beat(64'h0, 8'h00, 1'b0, 1'b0, hs);
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL empty_ready got %b exp 1", s_tready); end
    repeat (4) tick();
    checks++; if (obs.size() !== b) begin errors++; $display("FAIL empty_nonlast_count got %0d exp 0", obs.size() - b); end
    f = fd_cnt;
    send_beat(64'h0, 8'h00, 1'b1, 1'b1, hs);
    repeat (5) tick();
    checks++; if (obs.size() - b !== 1) begin errors++; $display("FAIL empty_last_count got %0d exp 1", obs.size() - b); end
    if (obs.size() > b) begin
      checks++; if (obs[b].d !== 8'h00) begin errors++; $display("FAIL empty_last_data got %h exp 00", obs[b].d); end
      checks++; if (obs[b].k !== 1'b0) begin errors++; $display("FAIL empty_last_keep got %b exp 0", obs[b].k); end
      checks++; if (obs[b].l !== 1'b1) begin errors++; $display("FAIL empty_last_last got %b exp 1", obs[b].l); end
      checks++; if (obs[b].u !== 1'b1) begin errors++; $display("FAIL empty_last_user got %b exp 1", obs[b].u); end
    end
    checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL empty_frame_done got %0d exp 1", fd_cnt - f); end
  endtask

  task automatic test_back_to_back();
    int b, hs;
    b = obs.size();
    send_beat(64'h0807060504030201, 8'hFF, 1'b1, 1'b0, hs);
    send_beat(64'h100F0E0D0C0B0A09, 8'hFF, 1'b1, 1'b1, hs);
    repeat (14) tick();
    checks++; if (obs.size() - b !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", obs.size() - b); end
    for (int i = 0; i < 16 && b + i < obs.size(); i++) begin
      checks++; if (obs[b+i].d !== 8'(i + 1)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, obs[b+i].d, 8'(i + 1)); end
      checks++; if (obs[b+i].l !== (i == 7 || i == 15)) begin errors++; $display("FAIL b2b_last[%0d] got %b", i, obs[b+i].l); end
      checks++; if (obs[b+i].u !== (i == 15)) begin errors++; $display("FAIL b2b_user[%0d] got %b exp %b", i, obs[b+i].u, (i == 15)); end
      checks++; if (obs[b+i].e !== obs[b].e + i) begin errors++; $display("FAIL b2b_bubble[%0d] got edge %0d exp %0d", i, obs[b+i].e, obs[b].e + i); end
    end
  endtask

  task automatic test_backpressure();
    int b, f;
    logic       stall;
    logic [7:0] sd;
    logic       sl;
    logic [0:0] sk;
    logic [3:0] pat;
    pat = 4'b1001;
    b = obs.size();
    f = fd_cnt;
    stall = 1'b0;
    sd = 8'h00;
    sl = 1'b0;
    sk = 1'b0;
    s_tdata  = 64'h0807060504030201;
    s_tkeep  = 8'hFF;
    s_tlast  = 1'b1;
    s_tuser  = 1'b0;
    s_tvalid = 1'b1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_accept_ready got %b exp 1", s_tready); end
    tick();
    s_tvalid = 1'b0;
    for (int k = 0; k < 48; k++) begin
      if (stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== sd || m_tlast !== sl || m_tkeep !== sk) begin
          errors++;
          $display("FAIL bp_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b", m_tvalid, m_tdata, m_tlast, sd, sl);
        end
      end
      if (obs.size() - b < 6) begin
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_early got %b exp 0 after %0d beats", s_tready, obs.size() - b); end
      end
      sd = m_tdata;
      sl = m_tlast;
      sk = m_tkeep;
      m_tready = pat[k % 4];
      stall = m_tvalid && !m_tready;
      tick();
    end
    m_tready = 1'b1;
    repeat (3) tick();
    checks++; if (obs.size() - b !== 8) begin errors++; $display("FAIL bp_count got %0d exp 8", obs.size() - b); end
    for (int i = 0; i < 8 && b + i < obs.size(); i++) begin
      checks++; if (obs[b+i].d !== 8'(i + 1)) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, obs[b+i].d, 8'(i + 1)); end
    end
    checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL bp_frame_done got %0d exp 1", fd_cnt - f); end
  endtask

  task automatic test_reset_mid();
    int b, f, n, hs;
    m_tready = 1'b1;
    b = obs.size();
    f = fd_cnt;
    send_beat(64'h0807060504030201, 8'hFF, 1'b1, 1'b0, hs);
    n = 0;
    while (obs.size() - b < 3 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (obs.size() - b < 3) begin errors++; $display("FAIL rstmid_wait got %0d beats exp 3", obs.size() - b); end
    rst = 1'b1;
    tick();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b exp 0", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready got %b exp 0", s_tready); end
    rst = 1'b0;
    tick();
    checks++; if (fd_cnt - f !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", fd_cnt - f); end
    b = obs.size();
    f = fd_cnt;
    send_beat(64'hB1B0AFAEADACABAA, 8'hFF, 1'b1, 1'b0, hs);
    repeat (14) tick();
    checks++; if (obs.size() - b !== 8) begin errors++; $display("FAIL rstmid_count got %0d exp 8", obs.size() - b); end
    for (int i = 0; i < 8 && b + i < obs.size(); i++) begin
      checks++; if (obs[b+i].d !== 8'(8'hAA + i)) begin errors++; $display("FAIL rstmid_data[%0d] got %h exp %h", i, obs[b+i].d, 8'(8'hAA + i)); end
      checks++; if (obs[b+i].l !== (i == 7)) begin errors++; $display("FAIL rstmid_last[%0d] got %b exp %b", i, obs[b+i].l, (i == 7)); end
    end
    checks++; if (fd_cnt - f !== 1) begin errors++; $display("FAIL rstmid_frame_done got %0d exp 1", fd_cnt - f); end
  endtask

  initial begin
    rst      = 1'b1;
    s_tdata  = 64'h0;
    s_tkeep  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tid    = 8'h00;
    s_tdest  = 8'h00;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    #1;
    test_reset();
    test_single();
    test_partial();
    test_sparse();
    test_empty();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_width_downsizer.md
Name: axis_width_downsizer

Overview:
- Single-clock AXI4-Stream narrowing converter: one wide input beat is split into several narrow output beats.
- Sits on the read side of the Ethernet TX path, after a wide async FIFO, and feeds byte- or narrow-lane MAC logic.
- Drops empty lanes at segment granularity and preserves frame boundaries.
- Carries tid, tdest and tuser through to the output.

Parameters:
S_DATA_WIDTH, 64, input data width in bits
S_KEEP_WIDTH, S_DATA_WIDTH/8, input tkeep width (lanes)
M_DATA_WIDTH, 8, output data width; must evenly divide S_DATA_WIDTH
M_KEEP_ENABLE, (M_DATA_WIDTH>8), drive m_axis_tkeep; when 0, tkeep is tied to all-ones except on the empty-last case
M_KEEP_WIDTH, M_DATA_WIDTH/8, output tkeep width; SEG_COUNT = S_KEEP_WIDTH/M_KEEP_WIDTH, must be >=2
ID_ENABLE, 0, propagate tid; when 0, output tid is 0
ID_WIDTH, 8, tid width
DEST_ENABLE, 0, propagate tdest; when 0, output tdest is 0
DEST_WIDTH, 8, tdest width
USER_ENABLE, 1, propagate tuser; when 0, output tuser is 0
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  S_DATA_WIDTH  input data
s_axis_tkeep  in  S_KEEP_WIDTH  input lane enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of frame
s_axis_tid  in  ID_WIDTH  stream id
s_axis_tdest  in  DEST_WIDTH  routing
s_axis_tuser  in  USER_WIDTH  sideband (bad-frame flag)
m_axis_tdata  out  M_DATA_WIDTH  output segment data
m_axis_tkeep  out  M_KEEP_WIDTH  output lane enables
m_axis_tvalid  out  1  output valid (registered)
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  end of frame
m_axis_tid  out  ID_WIDTH  stream id
m_axis_tdest  out  DEST_WIDTH  routing
m_axis_tuser  out  USER_WIDTH  sideband
m_status_frame_done  out  1  one-cycle pulse when an m_axis tlast beat transfers

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, named as in the rest of the codebase.
- Reset values: m_axis_tvalid=0, m_status_frame_done=0. Holding register is empty and output data/keep/last/id/dest/user are 0. s_axis_tready=0 while rst=1.
- Holding register: one wide beat (data, keep, last, id, dest, user) plus seg_mask[SEG_COUNT]. seg_mask[i] = OR of the keep bits of segment i. Segment 0 is the LSBs and is emitted first.
- Output register: loads when out_load = !m_axis_tvalid || m_axis_tready.
  - On load, takes the lowest set segment in seg_mask and clears that bit.
  - tlast_out = hold_last && (seg_mask is zero after the clear).
  - tuser_out = hold_user when tlast_out, else 0. tid and tdest are copied on every segment.
- Empty-last beat: keep all zero and tlast=1 emits exactly one beat with tdata=0, tkeep=0, tlast=1, tuser=hold_user. This preserves the frame boundary.
- Empty non-last beat: keep all zero and tlast=0 is discarded one cycle after acceptance, with no output.
- Handshake: s_axis_tready = !rst && (hold empty || hold is an empty non-last beat || (popcount(seg_mask)==1 && out_load)). Accepting into a hold register that is draining its final segment in the same cycle is legal.
- Latency: s handshake in cycle N gives m_axis_tvalid=1 in cycle N+2.
- Throughput: one segment per cycle under continuous m_axis_tready. Back-to-back input beats produce no bubble between them.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs stay stable.
- Sparse keep: middle-zero segments are skipped. Keep bits inside an emitted segment pass through unchanged.
- m_status_frame_done asserts the cycle after m_axis_tvalid && m_axis_tready && m_axis_tlast.
- rst mid-frame: the hold and output registers are flushed with no partial-frame recovery. The next frame starts cleanly.

Decomposition:
- No package: all derived constants (SEG_COUNT, SEG_DATA_W) are localparams.
- Sub-module axis_seg_pick: combinational lowest-set-index priority encoder over seg_mask. It returns the index, the post-clear mask, and a last-segment flag.
- Elaboration-time $error on a non-integer ratio, or when S and M word sizes differ.

Test Plan:
1. Single beat, 64b to 8b: tdata=0x0807060504030201, keep=0xFF, last=1, m_ready=1 -> 8 beats 0x01..0x08 on consecutive cycles, first at N+2; tlast only on 0x08; frame_done pulses once.
2. Partial keep: keep=0x0F, last=1 -> 4 beats 0x01..0x04; tlast on 0x04.
3. Sparse keep: keep=0x81, last=0, then keep=0x01, last=1 -> beats 0x01, 0x08, then the next beat's 0x01 with tlast.
4. Empty beats: keep=0x00, last=0 -> no output, tready returns within 1 cycle. keep=0x00, last=1, tuser=1 -> one beat with tkeep=0, tlast=1, tuser=1.
5. Backpressure: m_ready toggles 1,0,0,1 during a full frame -> outputs stable while stalled; all 8 bytes in order; s_axis_tready low until the final segment loads.
6. Reset after 3 of 8 segments emitted -> tvalid=0 the next cycle. A following frame 0xAA..0xB1 is emitted complete and correct.
